rv_alu_arb: RTL and testbench

Two-port arbiter that shares one combinational `rv_alu` instance between two requesters in the integer pipeline: port 0 is the EX-stage operate path and port 1 is the branch/address side unit. Each cycle it grants at most one requester in round-robin order and drives that requester's operands and control onto the shared ALU. It captures the ALU result into a per-port one-entry response register, which is returned through a valid/ready handshake. The ALU is instantiated beside this block; this block contains no arithmetic.

---
 rtl/rv_alu_arb.sv | 157 +++++++++++++++
 tb/tb_rv_alu_arb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_arb.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters. Each port returns its result through a one-entry response register.
`ifndef XLEN
`define XLEN 32
`endif

module rv_alu_arb_slot #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            grant,
  input  logic            rsp_ready,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  output logic            free,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_res,
  output logic            rsp_zero
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;

  // A full slot that drains this cycle can take a new result at the same edge.
  assign free = !valid_q || rsp_ready;

  always_comb begin
    valid_d = valid_q && !rsp_ready;
    res_d   = res_q;
    zero_d  = zero_q;
    if (grant) begin
      valid_d = 1'b1;
      res_d   = alu_res;
      zero_d  = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_res   = res_q;
  assign rsp_zero  = zero_q;
endmodule

module rv_alu_arb #(
  parameter int XLEN = `XLEN
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_req0_valid,
  input  logic            i_req1_valid,
  output logic            o_req0_ready,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic [XLEN-1:0] i_req1_b,
  input  logic [3:0]      i_req0_ctrl,
  input  logic [3:0]      i_req1_ctrl,
  output logic            o_rsp0_valid,
  output logic            o_rsp1_valid,
  input  logic            i_rsp0_ready,
  input  logic            i_rsp1_ready,
  output logic [XLEN-1:0] o_rsp0_res,
  output logic [XLEN-1:0] o_rsp1_res,
  output logic            o_rsp0_zero,
  output logic            o_rsp1_zero,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic            i_alu_zero
);
  localparam int NP = 2;

  logic [NP-1:0]           req_vld, rsp_rdy, free, elig, gnt;
  logic [NP-1:0]           rsp_vld, rsp_zero;
  logic [NP-1:0][XLEN-1:0] req_a, req_b, rsp_res;
  logic [NP-1:0][3:0]      req_ctrl;
  logic                    prio_q, prio_d;
  logic                    run_q;

  assign req_vld  = {i_req1_valid, i_req0_valid};
  assign rsp_rdy  = {i_rsp1_ready, i_rsp0_ready};
  assign req_a    = {i_req1_a, i_req0_a};
  assign req_b    = {i_req1_b, i_req0_b};
  assign req_ctrl = {i_req1_ctrl, i_req0_ctrl};

  // run_q keeps grants off from reset until the first edge after release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run_q  <= 1'b0;
      prio_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      prio_q <= prio_d;
    end
  end

  // Grant depends only on valids, slot state and prio, never on request data.
  always_comb begin
    elig = req_vld & free & {NP{run_q}};
    if (elig == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
    else               gnt = elig;
    prio_d = prio_q;
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;
  end

  always_comb begin
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = '0;
    for (int r = 0; r < NP; r++) begin
      if (gnt[r]) begin
        o_alu_a    = req_a[r];
        o_alu_b    = req_b[r];
        o_alu_ctrl = req_ctrl[r];
      end
    end
  end

  for (genvar r = 0; r < NP; r++) begin : g_slot
    rv_alu_arb_slot #(.XLEN(XLEN)) u_slot (
      .clk       (i_clk),
      .rstn      (i_rstn),
      .grant     (gnt[r]),
      .rsp_ready (rsp_rdy[r]),
      .alu_res   (i_alu_res),
      .alu_zero  (i_alu_zero),
      .free      (free[r]),
      .rsp_valid (rsp_vld[r]),
      .rsp_res   (rsp_res[r]),
      .rsp_zero  (rsp_zero[r])
    );
  end

  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];
  assign o_rsp0_valid = rsp_vld[0];
  assign o_rsp1_valid = rsp_vld[1];
  assign o_rsp0_res   = rsp_res[0];
  assign o_rsp1_res   = rsp_res[1];
  assign o_rsp0_zero  = rsp_zero[0];
  assign o_rsp1_zero  = rsp_zero[1];
endmodule

// File: tb/tb_rv_alu_arb.sv
// Randomized plus directed bench for rv_alu_arb with a behavioural ALU and a
// queue-based scoreboard; a separate monitor pops responses as they are taken.
module tb_rv_alu_arb;
  localparam int XLEN = 32;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

  logic clk = 1'b0, rstn = 1'b0;
  logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [XLEN-1:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
  logic [3:0] c0 = 0, c1 = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [XLEN-1:0] rsp0_res, rsp1_res, alu_a, alu_b, alu_res;
  logic [3:0] alu_ctrl;
  logic alu_zero;

  always #5 clk = ~clk;

  rv_alu_arb #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0_valid(v0), .i_req1_valid(v1),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .i_req0_a(a0), .i_req1_a(a1), .i_req0_b(b0), .i_req1_b(b1),
    .i_req0_ctrl(c0), .i_req1_ctrl(c1),
    .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
    .i_rsp0_ready(rr0), .i_rsp1_ready(rr1),
    .o_rsp0_res(rsp0_res), .o_rsp1_res(rsp1_res),
    .o_rsp0_zero(rsp0_zero), .o_rsp1_zero(rsp1_zero),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_res(alu_res), .i_alu_zero(alu_zero)
  );

  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, b, input logic [3:0] c);
    case (c)
      ADD:  return a + b;
      SUB:  return a - b;
      AND_: return a & b;
      OR_:  return a | b;
      XOR_: return a ^ b;
      SLL:  return a << b[4:0];
      SRL:  return a >> b[4:0];
      SRA:  return XLEN'($signed(a) >>> b[4:0]);
      SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      SLTU: return (a < b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_res == '0);

  typedef struct packed { logic [XLEN-1:0] res; logic zero; } rsp_t;
  rsp_t q0[$], q1[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot occupancy, favoured port and whether grants are enabled.
  bit occ0 = 0, occ1 = 0, armed = 0;
  int prio = 0;

  always @(negedge clk) begin
    bit f0, f1, e0, e1;
    int w;
    rsp_t e;
    if (!rstn) begin
      armed = 0; prio = 0; occ0 = 0; occ1 = 0;
      q0.delete(); q1.delete();
      chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
      chk("rst_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      chk("rst_res", {rsp1_res, rsp0_res}, 64'd0);
      chk("rst_zero", {62'd0, rsp1_zero, rsp0_zero}, 64'd0);
      chk("rst_alu", {28'd0, alu_ctrl, alu_a ^ alu_b}, 64'd0);
    end else begin
      chk("rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, {62'd0, occ1, occ0});
      f0 = !occ0 || rr0;
      f1 = !occ1 || rr1;
      e0 = armed && v0 && f0;
      e1 = armed && v1 && f1;
      if (e0 && e1) w = prio;
      else if (e0)  w = 0;
      else if (e1)  w = 1;
      else          w = -1;
      chk("grant", {62'd0, req1_ready, req0_ready},
          (w < 0) ? 64'd0 : (w == 0 ? 64'd1 : 64'd2));
      if (w == 0)      chk("alu_drive", {alu_a, alu_b}, {a0, b0});
      else if (w == 1) chk("alu_drive", {alu_a, alu_b}, {a1, b1});
      else             chk("alu_idle", {alu_a, alu_b}, 64'd0);
      chk("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, (w == 0) ? c0 : (w == 1) ? c1 : 4'd0});
      if (occ0 && rr0) occ0 = 0;
      if (occ1 && rr1) occ1 = 0;
      if (w == 0) begin
        e.res = alu_f(a0, b0, c0); e.zero = (e.res == 0);
        q0.push_back(e); occ0 = 1; prio = 1;
      end else if (w == 1) begin
        e.res = alu_f(a1, b1, c1); e.zero = (e.res == 0);
        q1.push_back(e); occ1 = 1; prio = 0;
      end
      armed = 1;
    end
  end

  // Monitor: pop on each response handshake, and require a held response to stay put.
  logic [XLEN:0] held0, held1;
  bit stall0 = 0, stall1 = 0;
  always @(negedge clk) begin
    rsp_t e;
    if (!rstn) begin
      stall0 = 0; stall1 = 0;
    end else begin
      if (stall0) chk("hold0", {31'd0, rsp0_res, rsp0_zero}, {31'd0, held0});
      if (stall1) chk("hold1", {31'd0, rsp1_res, rsp1_zero}, {31'd0, held1});
      if (rsp0_valid && rr0) begin
        if (q0.size() == 0) chk("q0_underflow", 64'd1, 64'd0);
        else begin e = q0.pop_front(); chk("rsp0", {31'd0, rsp0_res, rsp0_zero}, {31'd0, e}); end
      end
      if (rsp1_valid && rr1) begin
        if (q1.size() == 0) chk("q1_underflow", 64'd1, 64'd0);
        else begin e = q1.pop_front(); chk("rsp1", {31'd0, rsp1_res, rsp1_zero}, {31'd0, e}); end
      end
      stall0 = rsp0_valid && !rr0; held0 = {rsp0_res, rsp0_zero};
      stall1 = rsp1_valid && !rr1; held1 = {rsp1_res, rsp1_zero};
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic req(input logic rv0, input logic [XLEN-1:0] ra0, rb0, input logic [3:0] rc0,
                     input logic rv1, input logic [XLEN-1:0] ra1, rb1, input logic [3:0] rc1);
    v0 = rv0; a0 = ra0; b0 = rb0; c0 = rc0;
    v1 = rv1; a1 = ra1; b1 = rb1; c1 = rc1;
  endtask

  function automatic logic [XLEN-1:0] rnd_op();
    return ($urandom_range(0, 3) != 0) ? XLEN'($urandom) : XLEN'($urandom_range(0, 4));
  endfunction

  initial begin
    cyc(2);
    rstn = 1'b1; rr0 = 1; rr1 = 1;
    cyc(1);
    // single ADD on port 0
    req(1, 5, 3, ADD, 0, 0, 0, ADD); cyc(1);
    req(0, 0, 0, ADD, 1, 1, 1, ADD); cyc(1);   // port 1 once so prio returns to 0
    // dual requests alternate 0,1,0,1
    req(1, 7, 7, SUB, 1, 32'hF0, 32'h0F, XOR_); cyc(4);
    // stall port 1 and keep port 0 running
    req(0, 0, 0, ADD, 1, 9, 2, ADD); rr1 = 0; cyc(1);
    req(1, 1, 4, SLL, 1, 3, 3, SUB); cyc(3);
    rr1 = 1; req(0, 0, 0, ADD, 0, 0, 0, ADD); cyc(1);
    // fill port 0, then drain and refill in the same cycle
    rr0 = 0; req(1, 2, 2, ADD, 0, 0, 0, ADD); cyc(1);
    rr0 = 1; req(1, 32'hFFFF_FFFF, 1, SLT, 0, 0, 0, ADD); cyc(1);
    req(0, 0, 0, ADD, 0, 0, 0, ADD); cyc(1);
    // reset while both responses are held
    rr0 = 0; rr1 = 0; req(1, 4, 5, OR_, 1, 6, 7, AND_); cyc(2);
    rstn = 1'b0; cyc(2);
    rstn = 1'b1; rr0 = 1; rr1 = 1; req(1, 10, 3, SUB, 1, 10, 3, SRL); cyc(2);
    // idle
    req(0, 0, 0, ADD, 0, 0, 0, ADD);
    for (int i = 0; i < 5; i++) begin rr0 = 1'($urandom); rr1 = 1'($urandom); cyc(1); end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      req(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 4'($urandom_range(0, 9)),
          1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 4'($urandom_range(0, 9)));
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    req(0, 0, 0, ADD, 0, 0, 0, ADD); rr0 = 1; rr1 = 1; cyc(3);
    chk("drain", {32'd0, 16'(q0.size()), 16'(q1.size())}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
